// File: rtl/text_console.sv
// Command-driven tram writer for the textmode display: owns the cursor, colours,
// scroll offset and the tram write port, and runs line / screen clears as a small FSM.
module text_console #(
    parameter int WORD      = 32,
    parameter int ADDRW     = 14,
    parameter int CIDXW     = 4,
    parameter int TRAM_HRES = 84,
    parameter int TRAM_VRES = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [WORD-1:0]    cmd_data,
    output logic               tram_we,
    output logic [ADDRW-1:0]   tram_addr,
    output logic [WORD-1:0]    tram_data,
    output logic [ADDRW-1:0]   scroll_offs,
    output logic [ADDRW-1:0]   cur_x,
    output logic [ADDRW-1:0]   cur_y
);

    localparam int SIZE    = TRAM_HRES * TRAM_VRES;
    localparam int UCPW    = 21;
    localparam int UNUSEDW = WORD - 2 * CIDXW - UCPW;

    localparam logic [ADDRW:0]   SIZE_W   = (ADDRW+1)'(SIZE);
    localparam logic [ADDRW:0]   HRES_W   = (ADDRW+1)'(TRAM_HRES);
    localparam logic [ADDRW-1:0] HRES_M1  = ADDRW'(TRAM_HRES - 1);
    localparam logic [ADDRW-1:0] VRES_M1  = ADDRW'(TRAM_VRES - 1);
    localparam logic [ADDRW-1:0] SIZE_M1  = ADDRW'(SIZE - 1);
    localparam logic [15:0]      HRES_M16 = 16'(TRAM_HRES - 1);
    localparam logic [15:0]      VRES_M16 = 16'(TRAM_VRES - 1);

    localparam logic [1:0] OP_PUTC   = 2'd0;
    localparam logic [1:0] OP_CLEAR  = 2'd1;
    localparam logic [1:0] OP_SETCUR = 2'd2;
    localparam logic [1:0] OP_SETCOL = 2'd3;

    localparam logic [UCPW-1:0] UCP_CR    = 21'h0D;
    localparam logic [UCPW-1:0] UCP_LF    = 21'h0A;
    localparam logic [UCPW-1:0] UCP_SPACE = 21'h20;

    typedef enum logic [1:0] {IDLE, CLRLINE, CLRALL} state_t;

    state_t              state, state_n;
    logic [ADDRW-1:0]    cur_x_n, cur_y_n, scroll_offs_n;
    logic [ADDRW-1:0]    clr_cnt, clr_cnt_n, clr_base, clr_base_n;
    logic [CIDXW-1:0]    fg, fg_n, bg, bg_n;
    logic                tram_we_n;
    logic [ADDRW-1:0]    tram_addr_n;
    logic [WORD-1:0]     tram_data_n;

    logic [ADDRW:0]      lin_addr, scroll_sum;
    logic [ADDRW-1:0]    cell_addr, scroll_next;
    logic [WORD-1:0]     blank_word;
    logic [UCPW-1:0]     ucp;
    logic [15:0]         set_x, set_y;
    logic                newline, printable;

    // Sum stays below 2*SIZE, so one conditional subtract is a full modulo.
    assign lin_addr    = {1'b0, scroll_offs} + (ADDRW+1)'(cur_y) * HRES_W + {1'b0, cur_x};
    assign cell_addr   = ADDRW'((lin_addr >= SIZE_W) ? lin_addr - SIZE_W : lin_addr);
    assign scroll_sum  = {1'b0, scroll_offs} + HRES_W;
    assign scroll_next = ADDRW'((scroll_sum >= SIZE_W) ? scroll_sum - SIZE_W : scroll_sum);

    assign blank_word = {bg, fg, {UNUSEDW{1'b0}}, UCP_SPACE};
    assign ucp        = cmd_data[UCPW-1:0];
    assign set_x      = cmd_data[15:0];
    assign set_y      = cmd_data[31:16];
    assign cmd_ready  = (state == IDLE);

    always_comb begin
        state_n       = state;
        cur_x_n       = cur_x;
        cur_y_n       = cur_y;
        scroll_offs_n = scroll_offs;
        clr_cnt_n     = clr_cnt;
        clr_base_n    = clr_base;
        fg_n          = fg;
        bg_n          = bg;
        tram_we_n     = 1'b0;
        tram_addr_n   = tram_addr;
        tram_data_n   = tram_data;
        newline       = 1'b0;
        printable     = 1'b0;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_PUTC: begin
                            if (ucp == UCP_CR) begin
                                cur_x_n = '0;
                            end else if (ucp == UCP_LF) begin
                                newline = 1'b1;
                            end else begin
                                printable   = 1'b1;
                                tram_we_n   = 1'b1;
                                tram_addr_n = cell_addr;
                                tram_data_n = {bg, fg, {UNUSEDW{1'b0}}, ucp};
                                if (cur_x == HRES_M1) begin
                                    cur_x_n = '0;
                                    newline = 1'b1;
                                end else begin
                                    cur_x_n = cur_x + 1'b1;
                                end
                            end
                        end
                        OP_CLEAR: begin
                            scroll_offs_n = '0;
                            cur_x_n       = '0;
                            cur_y_n       = '0;
                            tram_we_n     = 1'b1;
                            tram_addr_n   = '0;
                            tram_data_n   = blank_word;
                            clr_cnt_n     = ADDRW'(1);
                            state_n       = CLRALL;
                        end
                        OP_SETCUR: begin
                            cur_x_n = (set_x > HRES_M16) ? HRES_M1 : ADDRW'(set_x);
                            cur_y_n = (set_y > VRES_M16) ? VRES_M1 : ADDRW'(set_y);
                        end
                        OP_SETCOL: begin
                            bg_n = cmd_data[2*CIDXW-1:CIDXW];
                            fg_n = cmd_data[CIDXW-1:0];
                        end
                        default: ;
                    endcase

                    if (newline) begin
                        if (cur_y < VRES_M1) begin
                            cur_y_n = cur_y + 1'b1;
                        end else begin
                            // The old top row becomes the new bottom row and must be blanked.
                            scroll_offs_n = scroll_next;
                            clr_base_n    = scroll_offs;
                            state_n       = CLRLINE;
                            if (printable) begin
                                clr_cnt_n = '0;
                            end else begin
                                tram_we_n   = 1'b1;
                                tram_addr_n = scroll_offs;
                                tram_data_n = blank_word;
                                clr_cnt_n   = ADDRW'(1);
                            end
                        end
                    end
                end
            end
            CLRLINE: begin
                // clr_base is a whole row below SIZE, so base+cnt never wraps.
                tram_we_n   = 1'b1;
                tram_addr_n = clr_base + clr_cnt;
                tram_data_n = blank_word;
                clr_cnt_n   = clr_cnt + 1'b1;
                if (clr_cnt == HRES_M1) state_n = IDLE;
            end
            CLRALL: begin
                tram_we_n   = 1'b1;
                tram_addr_n = clr_cnt;
                tram_data_n = blank_word;
                clr_cnt_n   = clr_cnt + 1'b1;
                if (clr_cnt == SIZE_M1) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cur_x       <= '0;
            cur_y       <= '0;
            scroll_offs <= '0;
            clr_cnt     <= '0;
            clr_base    <= '0;
            fg          <= '1;
            bg          <= '0;
            tram_we     <= 1'b0;
            tram_addr   <= '0;
            tram_data   <= '0;
        end else begin
            state       <= state_n;
            cur_x       <= cur_x_n;
            cur_y       <= cur_y_n;
            scroll_offs <= scroll_offs_n;
            clr_cnt     <= clr_cnt_n;
            clr_base    <= clr_base_n;
            fg          <= fg_n;
            bg          <= bg_n;
            tram_we     <= tram_we_n;
            tram_addr   <= tram_addr_n;
            tram_data   <= tram_data_n;
        end
    end

endmodule

// File: tb/tb_text_console.sv
// Directed bench for text_console: cursor, wrap, scroll, clear and reset-abort scenarios.
module tb_text_console;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op = 2'd0;
    logic [31:0] cmd_data = 32'd0;
    logic        cmd_ready;
    logic        tram_we;
    logic [13:0] tram_addr;
    logic [31:0] tram_data;
    logic [13:0] scroll_offs;
    logic [13:0] cur_x;
    logic [13:0] cur_y;

    int n_chk = 0;
    int n_fail = 0;

    localparam logic [31:0] BLANK_DEF = 32'h0F00_0020;
    localparam logic [31:0] BLANK_25  = 32'h2500_0020;

    text_console dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .tram_we(tram_we), .tram_addr(tram_addr), .tram_data(tram_data),
        .scroll_offs(scroll_offs), .cur_x(cur_x), .cur_y(cur_y)
    );

    always #5 clk = ~clk;

    // Waits (bounded) for cmd_ready, presents one command, returns 1ns after the accept edge.
    task automatic send(input logic [1:0] op, input logic [31:0] d);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        n_chk++;
        if (!cmd_ready) begin
            n_fail++;
            $display("FAIL send_timeout op=%0d got ready=%0b want 1", op, cmd_ready);
            return;
        end
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        n_chk++; if (tram_we !== 1'b0) begin n_fail++; $display("FAIL rst_we got %0b want 0", tram_we); end
        n_chk++; if (tram_addr !== 14'd0 || tram_data !== 32'd0) begin n_fail++; $display("FAIL rst_addr_data got %0h/%0h want 0/0", tram_addr, tram_data); end
        n_chk++; if (scroll_offs !== 14'd0 || cur_x !== 14'd0 || cur_y !== 14'd0) begin n_fail++; $display("FAIL rst_pos got %0d/%0d/%0d want 0/0/0", scroll_offs, cur_x, cur_y); end
        n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %0b want 1", cmd_ready); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_putc;
        send(2'd0, 32'h41);
        n_chk++; if (tram_we !== 1'b1 || tram_addr !== 14'd0) begin n_fail++; $display("FAIL putc_a_we_addr got %0b/%0d want 1/0", tram_we, tram_addr); end
        n_chk++; if (tram_data !== 32'h0F00_0041) begin n_fail++; $display("FAIL putc_a_data got %h want 0f000041", tram_data); end
        n_chk++; if (cur_x !== 14'd1 || cur_y !== 14'd0) begin n_fail++; $display("FAIL putc_a_cur got %0d,%0d want 1,0", cur_x, cur_y); end
        @(posedge clk); #1;
        n_chk++; if (tram_we !== 1'b0 || tram_addr !== 14'd0 || tram_data !== 32'h0F00_0041) begin n_fail++; $display("FAIL putc_hold got %0b/%0d/%h want 0/0/0f000041", tram_we, tram_addr, tram_data); end
    endtask

    task automatic test_wrap_row;
        send(2'd2, 32'h0000_0053);
        n_chk++; if (cur_x !== 14'd83 || cur_y !== 14'd0 || tram_we !== 1'b0) begin n_fail++; $display("FAIL setcur_83_0 got %0d,%0d we=%0b want 83,0 we=0", cur_x, cur_y, tram_we); end
        send(2'd0, 32'h42);
        n_chk++; if (tram_we !== 1'b1 || tram_addr !== 14'd83 || tram_data !== 32'h0F00_0042) begin n_fail++; $display("FAIL wrap_write got %0b/%0d/%h want 1/83/0f000042", tram_we, tram_addr, tram_data); end
        n_chk++; if (cur_x !== 14'd0 || cur_y !== 14'd1) begin n_fail++; $display("FAIL wrap_cur got %0d,%0d want 0,1", cur_x, cur_y); end
        n_chk++; if (cmd_ready !== 1'b1 || scroll_offs !== 14'd0) begin n_fail++; $display("FAIL wrap_ready got ready=%0b offs=%0d want 1/0", cmd_ready, scroll_offs); end
    endtask

    task automatic test_cr_lf;
        send(2'd2, 32'h0002_0005);
        send(2'd0, 32'h0D);
        n_chk++; if (tram_we !== 1'b0 || cur_x !== 14'd0 || cur_y !== 14'd2) begin n_fail++; $display("FAIL cr got we=%0b cur=%0d,%0d want 0 0,2", tram_we, cur_x, cur_y); end
        send(2'd0, 32'h0A);
        n_chk++; if (tram_we !== 1'b0 || cur_x !== 14'd0 || cur_y !== 14'd3 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL lf got we=%0b cur=%0d,%0d ready=%0b want 0 0,3 1", tram_we, cur_x, cur_y, cmd_ready); end
    endtask

    task automatic test_back_to_back;
        send(2'd2, 32'h0004_0000);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'd0;
        for (int i = 0; i < 3; i++) begin
            cmd_data = 32'h61 + i;
            @(posedge clk); #1;
            n_chk++; if (tram_we !== 1'b1 || tram_addr !== 14'(336 + i) || tram_data !== 32'h0F00_0061 + i) begin n_fail++; $display("FAIL b2b_%0d got %0b/%0d/%h want 1/%0d/%h", i, tram_we, tram_addr, tram_data, 336 + i, 32'h0F00_0061 + i); end
            n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_%0d got %0b want 1", i, cmd_ready); end
        end
        cmd_valid = 1'b0;
        n_chk++; if (cur_x !== 14'd3 || cur_y !== 14'd4) begin n_fail++; $display("FAIL b2b_cur got %0d,%0d want 3,4", cur_x, cur_y); end
    endtask

    task automatic test_scroll;
        send(2'd2, 32'h0017_0053);
        send(2'd0, 32'h43);
        n_chk++; if (tram_we !== 1'b1 || tram_addr !== 14'd2015 || tram_data !== 32'h0F00_0043) begin n_fail++; $display("FAIL scroll_char got %0b/%0d/%h want 1/2015/0f000043", tram_we, tram_addr, tram_data); end
        n_chk++; if (scroll_offs !== 14'd84 || cur_x !== 14'd0 || cur_y !== 14'd23) begin n_fail++; $display("FAIL scroll_state got offs=%0d cur=%0d,%0d want 84 0,23", scroll_offs, cur_x, cur_y); end
        n_chk++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL scroll_busy got %0b want 0", cmd_ready); end
        for (int i = 0; i < 84; i++) begin
            @(posedge clk); #1;
            n_chk++; if (tram_we !== 1'b1 || tram_addr !== 14'(i) || tram_data !== BLANK_DEF) begin n_fail++; $display("FAIL scroll_blank_%0d got %0b/%0d/%h want 1/%0d/%h", i, tram_we, tram_addr, tram_data, i, BLANK_DEF); end
            n_chk++; if (cmd_ready !== (i == 83)) begin n_fail++; $display("FAIL scroll_ready_%0d got %0b want %0b", i, cmd_ready, (i == 83)); end
        end
        @(posedge clk); #1;
        n_chk++; if (tram_we !== 1'b0) begin n_fail++; $display("FAIL scroll_end_we got %0b want 0", tram_we); end
    endtask

    task automatic test_scroll_wrap;
        for (int k = 1; k <= 23; k++) begin
            send(2'd0, 32'h0A);
            n_chk++; if (scroll_offs !== 14'((84 * (k + 1)) % 2016)) begin n_fail++; $display("FAIL lfscroll_offs_%0d got %0d want %0d", k, scroll_offs, (84 * (k + 1)) % 2016); end
            n_chk++; if (tram_we !== 1'b1 || tram_addr !== 14'(84 * k) || tram_data !== BLANK_DEF) begin n_fail++; $display("FAIL lfscroll_first_%0d got %0b/%0d/%h want 1/%0d/%h", k, tram_we, tram_addr, tram_data, 84 * k, BLANK_DEF); end
        end
        for (int i = 1; i < 84; i++) begin
            @(posedge clk); #1;
            n_chk++; if (tram_we !== 1'b1 || tram_addr !== 14'(1932 + i)) begin n_fail++; $display("FAIL lastclear_%0d got %0b/%0d want 1/%0d", i, tram_we, tram_addr, 1932 + i); end
        end
        n_chk++; if (cmd_ready !== 1'b1 || cur_y !== 14'd23 || scroll_offs !== 14'd0) begin n_fail++; $display("FAIL wrap_end got ready=%0b y=%0d offs=%0d want 1/23/0", cmd_ready, cur_y, scroll_offs); end
    endtask

    task automatic test_setcol_clear;
        send(2'd2, 32'h0005_000A);
        send(2'd3, 32'h25);
        n_chk++; if (tram_we !== 1'b0) begin n_fail++; $display("FAIL setcol_we got %0b want 0", tram_we); end
        send(2'd1, 32'h0);
        n_chk++; if (tram_we !== 1'b1 || tram_addr !== 14'd0 || tram_data !== BLANK_25) begin n_fail++; $display("FAIL clear_first got %0b/%0d/%h want 1/0/%h", tram_we, tram_addr, tram_data, BLANK_25); end
        n_chk++; if (cur_x !== 14'd0 || cur_y !== 14'd0 || scroll_offs !== 14'd0 || cmd_ready !== 1'b0) begin n_fail++; $display("FAIL clear_state got %0d,%0d offs=%0d ready=%0b want 0,0 0 0", cur_x, cur_y, scroll_offs, cmd_ready); end
        for (int i = 1; i < 2016; i++) begin
            @(posedge clk); #1;
            n_chk++; if (tram_we !== 1'b1 || tram_addr !== 14'(i) || tram_data !== BLANK_25) begin n_fail++; $display("FAIL clear_%0d got %0b/%0d/%h want 1/%0d/%h", i, tram_we, tram_addr, tram_data, i, BLANK_25); end
            n_chk++; if (cmd_ready !== (i == 2015)) begin n_fail++; $display("FAIL clear_ready_%0d got %0b want %0b", i, cmd_ready, (i == 2015)); end
        end
        @(posedge clk); #1;
        n_chk++; if (tram_we !== 1'b0 || tram_addr !== 14'd2015 || tram_data !== BLANK_25) begin n_fail++; $display("FAIL clear_hold got %0b/%0d/%h want 0/2015/%h", tram_we, tram_addr, tram_data, BLANK_25); end
    endtask

    task automatic test_reset_mid_clear;
        int n = 0;
        send(2'd1, 32'h0);
        while (tram_addr !== 14'd100 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        n_chk++; if (tram_addr !== 14'd100) begin n_fail++; $display("FAIL midclr_reach got %0d want 100", tram_addr); end
        rst_n = 1'b0;
        #1;
        n_chk++; if (tram_we !== 1'b0) begin n_fail++; $display("FAIL midclr_we got %0b want 0", tram_we); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        n_chk++; if (cmd_ready !== 1'b1 || tram_we !== 1'b0) begin n_fail++; $display("FAIL midclr_idle got ready=%0b we=%0b want 1/0", cmd_ready, tram_we); end
        send(2'd2, 32'h0063_00C8);
        n_chk++; if (cur_x !== 14'd83 || cur_y !== 14'd23) begin n_fail++; $display("FAIL clamp got %0d,%0d want 83,23", cur_x, cur_y); end
        send(2'd2, 32'h0001_0002);
        send(2'd0, 32'h5A);
        n_chk++; if (tram_we !== 1'b1 || tram_addr !== 14'd86 || tram_data !== 32'h0F00_005A) begin n_fail++; $display("FAIL post_rst_putc got %0b/%0d/%h want 1/86/0f00005a", tram_we, tram_addr, tram_data); end
    endtask

    initial begin
        test_reset();
        test_putc();
        test_wrap_row();
        test_cr_lf();
        test_back_to_back();
        test_scroll();
        test_scroll_wrap();
        test_setcol_clear();
        test_reset_mid_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
